// File: rtl/stopwatch_datapath.sv
// Stopwatch datapath: tenth-second prescaler, M:SS.T BCD time counter,
// lap register, button synchronisers with rising-edge detectors, and the
// display multiplexer. Executes the 6-bit control word from the control
// unit and returns status {S2, S1, tenth}.
module stopwatch_datapath #(
    parameter int PRESCALE   = 5000000,
    parameter int PRESCALE_W = 23
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  cw,
    input  logic [1:0]  btn,
    output logic [2:0]  sw,
    output logic [15:0] display
);

    localparam logic [PRESCALE_W-1:0] PRESC_MAX = PRESCALE_W'(PRESCALE - 1);
    localparam logic [PRESCALE_W-1:0] PRESC_ONE = {{(PRESCALE_W-1){1'b0}}, 1'b1};

    logic [PRESCALE_W-1:0] presc_q, presc_d;
    logic [15:0]           tcnt_q, tcnt_d;   // {min, sec_tens, sec_units, tenths}
    logic [15:0]           lap_q, lap_d;
    logic [1:0]            sync1_q, sync2_q, prev_q;
    logic                  tenth;
    logic [1:0]            press;

    // Prescaler next value: hold, count with wrap at PRESCALE-1, or clear.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        presc_d = presc_q;
        unique case (cw[1:0])
            2'b00:   presc_d = presc_q;
            2'b01:   presc_d = (presc_q == PRESC_MAX) ? '0 : presc_q + PRESC_ONE;
            default: presc_d = '0;
        endcase
    end

    // Tick is combinational so it lines up with the wrap cycle of the prescaler.
    assign tenth = (presc_q == PRESC_MAX) && (cw[1:0] == 2'b01);

    // Time counter next value: BCD ripple increment with full wrap at 9:59.9.
    always_comb begin
        tcnt_d = tcnt_q;
        unique case (cw[3:2])
            2'b01: begin
                if (tcnt_q[3:0] != 4'd9) begin
                    tcnt_d[3:0] = tcnt_q[3:0] + 4'd1;
                end else begin
                    tcnt_d[3:0] = 4'd0;
                    if (tcnt_q[7:4] != 4'd9) begin
                        tcnt_d[7:4] = tcnt_q[7:4] + 4'd1;
                    end else begin
                        tcnt_d[7:4] = 4'd0;
                        if (tcnt_q[11:8] != 4'd5) begin
                            tcnt_d[11:8] = tcnt_q[11:8] + 4'd1;
                        end else begin
                            tcnt_d[11:8]  = 4'd0;
                            tcnt_d[15:12] = (tcnt_q[15:12] == 4'd9) ? 4'd0
                                                                    : tcnt_q[15:12] + 4'd1;
                        end
                    end
                end
            end
            2'b10:   tcnt_d = '0;
            default: tcnt_d = tcnt_q;
        endcase
    end

    // Lap captures the current (pre-increment) register value when loaded.
    always_comb begin
        lap_d = cw[4] ? tcnt_q : lap_q;
    end

    // State registers; button flops reset to 1 so a held button is not a press.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: reset every state flop here; the registers are small and a held button must not pulse.
        if (reset) begin
            presc_q <= '0;
            tcnt_q  <= '0;
            lap_q   <= '0;
            sync1_q <= 2'b11;
            sync2_q <= 2'b11;
            prev_q  <= 2'b11;
        end else begin
            // NOTE: non-blocking so every flop samples pre-edge values (sync chain stays two stages).
            presc_q <= presc_d;
            tcnt_q  <= tcnt_d;
            lap_q   <= lap_d;
            sync1_q <= btn;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    // Rising-edge pulses from the synchronised buttons, and output muxing.
    assign press   = sync2_q & ~prev_q;
    assign sw      = {press[1], press[0], tenth};
    assign display = cw[5] ? lap_q : tcnt_q;

endmodule

// File: tb/tb_stopwatch_datapath.sv
// Self-checking bench for stopwatch_datapath with PRESCALE=4: a vector table
// for prescaler/increment/clear basics, plus hand sequences for counter wrap,
// clear, lap, buttons and asynchronous reset.
module tb_stopwatch_datapath;

    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  cw;
    logic [1:0]  btn;
    logic [2:0]  sw;
    logic [15:0] display;

    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        logic [5:0]  cw;
        logic [1:0]  btn;
        logic [2:0]  exp_sw;
        logic [15:0] exp_disp;
    } vec_t;

    vec_t vecs[$];

    stopwatch_datapath #(.PRESCALE(4), .PRESCALE_W(3)) dut (
        .clk     (clk),
        .reset   (reset),
        .cw      (cw),
        .btn     (btn),
        .sw      (sw),
        .display (display)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Advance one edge and settle 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    // Independent BCD model of a tenths count: M:SS.T.
    function automatic logic [15:0] to_bcd(input int n);
        logic [15:0] r;
        r[3:0]   = 4'(n % 10);
        r[7:4]   = 4'((n / 10) % 10);
        r[11:8]  = 4'((n / 100) % 6);
        r[15:12] = 4'((n / 600) % 10);
        return r;
    endfunction

    initial begin
        reset = 1'b1;
        cw    = 6'b000000;
        btn   = 2'b00;
        #1;
        check("reset_display", display, 16'h0000);
        check("reset_sw", {13'd0, sw}, 16'h0000);
        reset = 1'b0;

        // ---- table: prescaler ticks, hold, increment, clear ----
        for (int k = 1; k <= 15; k++)
            vecs.push_back('{6'b000001, 2'b00, (k % 4 == 0) ? 3'b001 : 3'b000, 16'h0000});
        vecs.push_back('{6'b000000, 2'b00, 3'b000, 16'h0000});  // count=3 but hold -> no tick
        vecs.push_back('{6'b000001, 2'b00, 3'b001, 16'h0000});  // count=3, counting -> tick
        vecs.push_back('{6'b000100, 2'b00, 3'b000, 16'h0000});
        vecs.push_back('{6'b000100, 2'b00, 3'b000, 16'h0001});
        vecs.push_back('{6'b001011, 2'b00, 3'b000, 16'h0002});
        vecs.push_back('{6'b000000, 2'b00, 3'b000, 16'h0000});

        do_reset();
        foreach (vecs[i]) begin
            cw  = vecs[i].cw;
            btn = vecs[i].btn;
            #1;
            check($sformatf("vec%0d_sw", i), {13'd0, sw}, {13'd0, vecs[i].exp_sw});
            check($sformatf("vec%0d_disp", i), display, vecs[i].exp_disp);
            tick();
        end

        // ---- increment and wrap ----
        do_reset();
        cw = 6'b000100;
        for (int i = 1; i <= 6000; i++) begin
            tick();
            if (i == 99 || i == 100 || i == 1234 || i == 5999 || i == 6000)
                check($sformatf("inc_%0d", i), display, to_bcd(i));
        end
        check("wrap_model_9599", to_bcd(5999), 16'h9599);

        // ---- clear with prescaler active ----
        do_reset();
        cw = 6'b000101;
        repeat (123) tick();
        #1;
        check("clr_pre_disp", display, 16'h0123);
        check("clr_pre_sw", {13'd0, sw}, 16'h0001);
        cw = 6'b001011;
        #1;
        check("clr_cycle_sw", {13'd0, sw}, 16'h0000);
        tick();
        cw = 6'b000001;
        for (int k = 0; k < 4; k++) begin
            #1;
            check($sformatf("clr_presc_%0d", k), {13'd0, sw}, (k == 3) ? 16'h0001 : 16'h0000);
            check($sformatf("clr_disp_%0d", k), display, 16'h0000);
            tick();
        end

        // ---- lap capture with simultaneous increment ----
        do_reset();
        cw = 6'b000100;
        repeat (42) tick();
        cw = 6'b010100;
        #1;
        check("lap_live_before", display, 16'h0042);
        tick();
        cw = 6'b100000;
        #1;
        check("lap_shown", display, 16'h0042);
        cw = 6'b000000;
        #1;
        check("lap_live_after", display, 16'h0043);

        // ---- buttons ----
        do_reset();
        cw  = 6'b000000;
        btn = 2'b00;
        repeat (9) tick();
        btn = 2'b01;                       // raw rise between edges 9 and 10
        tick();                            // after edge 10: sampled into sync1
        check("s1_e10", {13'd0, sw}, 16'h0000);
        tick();                            // after edge 11: pulse
        check("s1_e11", {13'd0, sw}, 16'h0002);
        for (int k = 0; k < 20; k++) begin
            tick();
            check($sformatf("s1_hold_%0d", k), {13'd0, sw}, 16'h0000);
        end
        btn = 2'b00;
        repeat (4) tick();
        btn = 2'b11;
        tick();
        check("s12_first", {13'd0, sw}, 16'h0000);
        tick();
        check("s12_pulse", {13'd0, sw}, 16'h0006);
        tick();
        check("s12_after", {13'd0, sw}, 16'h0000);
        // held through reset release: no pulse
        do_reset();
        for (int k = 0; k < 5; k++) begin
            check($sformatf("held_reset_%0d", k), {13'd0, sw}, 16'h0000);
            tick();
        end
        btn = 2'b00;

        // ---- asynchronous reset mid-count ----
        do_reset();
        repeat (3) tick();
        cw = 6'b000101;
        repeat (7) tick();
        #1;
        check("ar_pre_disp", display, 16'h0007);
        check("ar_pre_sw", {13'd0, sw}, 16'h0001);
        reset = 1'b1;                      // between edges
        #1;
        check("ar_disp", display, 16'h0000);
        check("ar_sw", {13'd0, sw}, 16'h0000);
        #2;
        reset = 1'b0;
        tick();
        check("ar_resume", display, 16'h0001);
        tick();
        check("ar_resume2", display, 16'h0002);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
